// File: rtl/rr_issue_arbiter_if.sv
// rr_issue_arbiter_if: request/grant bundle between requesters, consumer and
// the round-robin issue arbiter. The master side drives requests and the
// consumer handshake. The slave side is the arbiter, which returns the grant.
interface rr_issue_arbiter_if #(
   parameter int N_REQS = 4
);
   localparam int IDX_W = $clog2(N_REQS);

   logic [N_REQS-1:0] req;
   logic              out_ready;
   logic              lock;
   logic [N_REQS-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_valid;

   modport master (
      output req, out_ready, lock,
      input  gnt, gnt_idx, gnt_valid
   );

   modport slave (
      input  req, out_ready, lock,
      output gnt, gnt_idx, gnt_valid
   );
endinterface

// File: rtl/rr_issue_arbiter.sv
// rr_issue_arbiter: round-robin arbiter sharing one issue port among N_REQS
// requesters. It holds a registered one-hot grant and an encoded index until
// the consumer accepts the grant. It then rotates priority past the winner.
// A back-to-back reload in the accept cycle gives one grant per cycle under
// continuous requests.
// Optional feature macro: RR_ARB_LOCK_EN. When defined, an accept with lock=1
// re-grants the same requester while it still requests, and priority does not
// rotate.
module rr_issue_arbiter #(
   parameter int N_REQS = 4
) (
   input  logic               clk,
   input  logic               rst,
   rr_issue_arbiter_if.slave  bus
);
   localparam int IDX_W = $clog2(N_REQS);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]        state_r;
   logic [IDX_W-1:0]  ptr_r;
   logic [N_REQS-1:0] gnt_r;
   logic [IDX_W-1:0]  gnt_idx_r;
   logic              gnt_valid_r;

   logic              accept_s;
   logic              lock_hit_s;
   logic              load_s;
   logic [IDX_W-1:0]  ptr_next_s;
   logic [IDX_W-1:0]  win_idx_s;
   logic              found_s;
   logic [N_REQS-1:0] win_onehot_s;

   // Accept happens only while a grant is being presented.
   assign accept_s = (state_r == GRANT) & bus.out_ready;

`ifdef RR_ARB_LOCK_EN
   // Burst ownership: keep the current winner if it still requests.
   assign lock_hit_s = accept_s & bus.lock & bus.req[gnt_idx_r];
`else
   logic lock_unused_s;
   assign lock_unused_s = bus.lock;
   assign lock_hit_s    = 1'b0;
`endif

   // Next priority pointer: step past the accepted winner, with wrap, unless locked.
   always_comb begin
      ptr_next_s = ptr_r;
      if (lock_hit_s) begin
         ptr_next_s = ptr_r;
      end else if (accept_s) begin
         if (gnt_idx_r == IDX_W'(N_REQS - 1)) begin
            ptr_next_s = '0;
         end else begin
            ptr_next_s = gnt_idx_r + IDX_W'(1);
         end
      end else begin
         ptr_next_s = ptr_r;
      end
   end

   // Winner select: first requester at or after the next pointer, circularly.
   // A lock hit forces the current winner.
   always_comb begin
      int cand;
      found_s   = 1'b0;
      win_idx_s = '0;
      cand      = 0;
      if (lock_hit_s) begin
         found_s   = 1'b1;
         win_idx_s = gnt_idx_r;
      end else begin
         for (int k = 0; k < N_REQS; k++) begin
            cand = (int'(ptr_next_s) + k) % N_REQS;
            if (!found_s && bus.req[cand]) begin
               found_s   = 1'b1;
               win_idx_s = IDX_W'(cand);
            end else begin
               found_s   = found_s;
            end
         end
      end
   end

   assign win_onehot_s = {{(N_REQS-1){1'b0}}, 1'b1} << win_idx_s;
   assign load_s       = ((state_r == IDLE) | accept_s) & (|bus.req);

   // Grant registers, state and priority pointer. An unaccepted grant holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         gnt_r       <= '0;
         gnt_idx_r   <= '0;
         gnt_valid_r <= 1'b0;
      end else begin
         ptr_r <= ptr_next_s;
         if (load_s && found_s) begin
            state_r     <= GRANT;
            gnt_r       <= win_onehot_s;
            gnt_idx_r   <= win_idx_s;
            gnt_valid_r <= 1'b1;
         end else if (accept_s) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
         end else begin
            state_r     <= state_r;
            gnt_r       <= gnt_r;
            gnt_idx_r   <= gnt_idx_r;
            gnt_valid_r <= gnt_valid_r;
         end
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_idx   = gnt_idx_r;
   assign bus.gnt_valid = gnt_valid_r;
endmodule

// File: tb/tb_rr_issue_arbiter.sv
// tb_rr_issue_arbiter: directed cycle table for rr_issue_arbiter (N_REQS=4).
// Each row is applied for one clock and the registered outputs are compared
// after that edge. Hand-written sequences follow for the starvation bound and
// for the output invariants.
module tb_rr_issue_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   rr_issue_arbiter_if #(.N_REQS(4)) bus();

   rr_issue_arbiter #(.N_REQS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic       lock;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] q, input logic y,
                               input logic l, input logic [3:0] g,
                               input logic [1:0] x, input logic v);
      vec_t e;
      e.rst = r; e.req = q; e.rdy = y; e.lock = l;
      e.gnt = g; e.idx = x; e.vld = v;
      vecs.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0] prev_gnt;
      logic       prev_vld;
      logic       prev_rdy;
      int         cycles;
      logic       seen3;

      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.req = 4'b0000;
      bus.out_ready = 1'b0;
      bus.lock = 1'b0;

      // rst, req, rdy, lock -> gnt, idx, vld (values after the edge)
      add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 0 reset
      add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 1 reset
      add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1); // 2 first grant
      add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1); // 3
      add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1); // 4
      add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1); // 5
      add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1); // 6 wrap
      add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 7 accept, no req -> idle
      add(1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0); // 8 reset
      add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1); // 9 grant 0
      add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1); // 10 hold
      add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1); // 11 hold
      add(1'b0, 4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1); // 12 accept -> idx 2
      add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1); // 13 req drops, hold
      add(1'b0, 4'b1001, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1); // 14 ptr 3
      add(1'b0, 4'b1001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1); // 15 wrap to 0
      add(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1); // 16
      add(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1); // 17 hold, ptr 1
      add(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0); // 18 reset mid-grant
      add(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1); // 19 ptr back to 0
      add(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1); // 20
      add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 21 idle, ptr 2
      add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 22 ready while idle
      add(1'b0, 4'b0111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1); // 23 ptr 2 held
      add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1); // 24 ptr 3 -> scan 3,0
`ifdef RR_ARB_LOCK_EN
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1); // 25 locked
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1); // 26 locked
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1); // 27 locked
      add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1); // 28 unlock -> 1
`else
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1); // 25 lock ignored
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1); // 26
      add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1); // 27
      add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1); // 28
`endif
      add(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1); // 29
      add(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1); // 30 lock w/o req = no lock
      add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0); // 31 idle

      for (int i = 0; i < vecs.size(); i++) begin
         rst           = vecs[i].rst;
         bus.req       = vecs[i].req;
         bus.out_ready = vecs[i].rdy;
         bus.lock      = vecs[i].lock;
         @(posedge clk);
         #1;
         check($sformatf("row%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
         check($sformatf("row%0d_idx", i), 32'(bus.gnt_idx), 32'(vecs[i].idx));
         check($sformatf("row%0d_vld", i), 32'(bus.gnt_valid), 32'(vecs[i].vld));
      end

      // Starvation bound: with all requesting, requester 3 wins on the 4th grant.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req = 4'b1111;
      bus.out_ready = 1'b1;
      bus.lock = 1'b0;
      cycles = 0;
      seen3 = 1'b0;
      while (!seen3 && cycles < 8) begin
         @(posedge clk);
         #1;
         cycles++;
         seen3 = bus.gnt[3];
      end
      check("starve_seen3", 32'(seen3), 32'd1);
      check("starve_cycles", 32'(cycles), 32'd4);

      // Invariants under pseudo-random requests, handshake and lock.
      prev_gnt = bus.gnt;
      prev_vld = bus.gnt_valid;
      for (int c = 0; c < 60; c++) begin
         bus.req       = 4'($urandom_range(0, 15));
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.lock      = 1'($urandom_range(0, 1));
         prev_rdy      = bus.out_ready;
         @(posedge clk);
         #1;
         check($sformatf("inv%0d_vld_or", c), 32'(bus.gnt_valid), 32'(|bus.gnt));
         if (bus.gnt_valid) begin
            check($sformatf("inv%0d_onehot", c), 32'(bus.gnt), 32'(4'b0001 << bus.gnt_idx));
         end else begin
            check($sformatf("inv%0d_idx0", c), 32'(bus.gnt_idx), 32'd0);
         end
         if (prev_vld && !prev_rdy) begin
            check($sformatf("inv%0d_hold", c), 32'(bus.gnt), 32'(prev_gnt));
         end else begin
            prev_rdy = prev_rdy;
         end
         prev_gnt = bus.gnt;
         prev_vld = bus.gnt_valid;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
